// File: rtl/clk_div_pkg.sv
// Shared constants, config request type and helpers for the clk_div_bank divider slice.
package clk_div_pkg;

   localparam int DEF_NCH     = 4;
   localparam int DEF_DW      = 16;
   localparam int DEF_DIV_RST = 2;

   // Widest channel select (16 channels) and widest divisor the bank supports.
   localparam int MAX_CHW = 4;
   localparam int MAX_DW  = 32;

   typedef struct packed {
      logic [MAX_CHW-1:0] chan;
      logic [MAX_DW-1:0]  div;
   } cfg_req_t;

   // Counter values below this threshold drive the high half of the period.
   function automatic logic [MAX_DW-1:0] half_thr(input logic [MAX_DW-1:0] div);
      return div >> 1;
   endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, active/shadow divisor, level output and period tick.
module clk_div_chan
   import clk_div_pkg::*;
#(
   parameter int DW      = DEF_DW,
   parameter int DIV_RST = DEF_DIV_RST
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          sync,
   input  logic          load,
   input  logic [DW-1:0] load_div,
   output logic          pend,
   output logic          div_out,
   output logic          tick
);

   logic [DW-1:0] cnt_reg, cnt_next;
   logic [DW-1:0] div_reg, shadow_reg, div_eff, nxt;
   logic          pend_reg, div_out_reg, div_out_next, tick_reg, tick_next;
   logic          wrap, apply;

   always_comb begin
      wrap         = (cnt_reg == div_reg - DW'(1));
      // A pending divisor only takes over at a period boundary, so no period is cut short.
      apply        = pend_reg && (!en || sync || wrap);
      div_eff      = apply ? shadow_reg : div_reg;
      nxt          = wrap ? '0 : cnt_reg + DW'(1);
      cnt_next     = '0;
      div_out_next = 1'b0;
      tick_next    = 1'b0;
      if (en && !sync) begin
         cnt_next     = nxt;
         div_out_next = (nxt < DW'(half_thr(MAX_DW'(div_eff))));
         tick_next    = wrap;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_reg     <= '0;
         div_reg     <= DW'(DIV_RST);
         shadow_reg  <= '0;
         pend_reg    <= 1'b0;
         div_out_reg <= 1'b0;
         tick_reg    <= 1'b0;
      end else begin
         cnt_reg     <= cnt_next;
         div_out_reg <= div_out_next;
         tick_reg    <= tick_next;
         // load is only ever granted while pend is clear, so it never collides with apply.
         if (apply) begin
            div_reg  <= shadow_reg;
            pend_reg <= 1'b0;
         end else if (load) begin
            shadow_reg <= load_div;
            pend_reg   <= 1'b1;
         end
      end
   end

   assign pend    = pend_reg;
   assign div_out = div_out_reg;
   assign tick    = tick_reg;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NCH programmable dividers producing level outputs and period ticks,
// with a valid/ready port for runtime divisor updates.
module clk_div_bank
   import clk_div_pkg::*;
#(
   parameter int  NCH     = DEF_NCH,
   parameter int  DW      = DEF_DW,
   parameter int  DIV_RST = DEF_DIV_RST,
   localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
)(
   input  logic           clk,
   input  logic           rst,
   input  logic [NCH-1:0] en,
   input  logic           sync,
   input  logic           cfg_valid,
   output logic           cfg_ready,
   input  logic [CHW-1:0] cfg_chan,
   input  logic [DW-1:0]  cfg_div,
   output logic           cfg_err,
   output logic [NCH-1:0] div_out,
   output logic [NCH-1:0] tick
);

   cfg_req_t       req;
   logic           in_range, req_ok, accept;
   logic           cfg_err_reg;
   logic [NCH-1:0] pend, load;

   assign req.chan = MAX_CHW'(cfg_chan);
   assign req.div  = MAX_DW'(cfg_div);

   assign in_range  = (int'(req.chan) < NCH);
   assign req_ok    = in_range && (req.div != '0);
   // Out-of-range selects have no channel to stall on; they are accepted and flagged.
   assign cfg_ready = in_range ? ~pend[cfg_chan] : 1'b1;
   assign accept    = cfg_valid && cfg_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cfg_err_reg <= 1'b0;
      end else begin
         cfg_err_reg <= accept && !req_ok;
      end
   end

   assign cfg_err = cfg_err_reg;

   for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
      assign load[gi] = accept && req_ok && (req.chan == MAX_CHW'(gi));

      clk_div_chan #(
         .DW      (DW),
         .DIV_RST (DIV_RST)
      ) u_chan (
         .clk      (clk),
         .rst      (rst),
         .en       (en[gi]),
         .sync     (sync),
         .load     (load[gi]),
         .load_div (cfg_div),
         .pend     (pend[gi]),
         .div_out  (div_out[gi]),
         .tick     (tick[gi])
      );
   end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed self-checking bench for clk_div_bank: reset, reprogramming, back-pressure,
// invalid requests, sync alignment and asynchronous reset during a pending update.
module tb_clk_div_bank;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  en;
   logic        sync;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [1:0]  cfg_chan;
   logic [15:0] cfg_div;
   logic        cfg_err;
   logic [3:0]  div_out;
   logic [3:0]  tick;

   // Five-channel instance so that a select of 5 is genuinely out of range.
   logic [4:0]  en5;
   logic        cfg_valid5;
   logic        cfg_ready5;
   logic [2:0]  cfg_chan5;
   logic [15:0] cfg_div5;
   logic        cfg_err5;
   logic [4:0]  div_out5;
   logic [4:0]  tick5;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   clk_div_bank #(.NCH(4), .DW(16), .DIV_RST(2)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .sync      (sync),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_chan  (cfg_chan),
      .cfg_div   (cfg_div),
      .cfg_err   (cfg_err),
      .div_out   (div_out),
      .tick      (tick)
   );

   clk_div_bank #(.NCH(5), .DW(16), .DIV_RST(2)) u_dut5 (
      .clk       (clk),
      .rst       (rst),
      .en        (en5),
      .sync      (sync),
      .cfg_valid (cfg_valid5),
      .cfg_ready (cfg_ready5),
      .cfg_chan  (cfg_chan5),
      .cfg_div   (cfg_div5),
      .cfg_err   (cfg_err5),
      .div_out   (div_out5),
      .tick      (tick5)
   );

   task automatic test_reset();
      logic [3:0] exp;
      rst = 1'b0; en = '0; sync = 1'b0; cfg_valid = 1'b0; cfg_chan = '0; cfg_div = '0;
      en5 = '0; cfg_valid5 = 1'b0; cfg_chan5 = '0; cfg_div5 = '0;
      repeat (3) @(negedge clk);
      total_cnt++;
      if ({div_out, tick, cfg_err, cfg_ready} !== 10'b0000_0000_0_1)
         $display("FAIL reset_outputs: got %b expected %b", {div_out, tick, cfg_err, cfg_ready}, 10'b0000_0000_0_1);
      else pass_cnt++;
      rst = 1'b1; en = 4'b0001;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         exp = (i % 2 == 1) ? 4'b0001 : 4'b0000;
         total_cnt++;
         if (div_out !== exp) $display("FAIL reset_div2_out cyc%0d: got %b expected %b", i, div_out, exp);
         else pass_cnt++;
         total_cnt++;
         if (tick !== exp) $display("FAIL reset_div2_tick cyc%0d: got %b expected %b", i, tick, exp);
         else pass_cnt++;
      end
      $display("reset: ch0 default divide-by-2 checked");
   endtask

   task automatic test_reprogram();
      logic [9:0] exp_o, exp_t;
      en = 4'b0000; @(negedge clk);
      en = 4'b0010; @(negedge clk); @(negedge clk);
      total_cnt++;
      if (tick[1] !== 1'b1) $display("FAIL reprog_start_tick: got %b expected 1", tick[1]);
      else pass_cnt++;
      cfg_chan = 2'd1; cfg_div = 16'd5; cfg_valid = 1'b1; #1;
      total_cnt++;
      if (cfg_ready !== 1'b1) $display("FAIL reprog_ready_idle: got %b expected 1", cfg_ready);
      else pass_cnt++;
      @(negedge clk); cfg_valid = 1'b0; #1;
      total_cnt++;
      if (cfg_ready !== 1'b0) $display("FAIL reprog_ready_pend: got %b expected 0", cfg_ready);
      else pass_cnt++;
      exp_o = 10'b1100011000;
      exp_t = 10'b1000010000;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         total_cnt++;
         if (div_out[1] !== exp_o[9-i]) $display("FAIL reprog_div5_out cyc%0d: got %b expected %b", i, div_out[1], exp_o[9-i]);
         else pass_cnt++;
         total_cnt++;
         if (tick[1] !== exp_t[9-i]) $display("FAIL reprog_div5_tick cyc%0d: got %b expected %b", i, tick[1], exp_t[9-i]);
         else pass_cnt++;
      end
      total_cnt++;
      if (cfg_ready !== 1'b1) $display("FAIL reprog_ready_after: got %b expected 1", cfg_ready);
      else pass_cnt++;
      $display("reprogram: ch1 2 -> 5 checked");
   endtask

   task automatic test_back_to_back();
      logic [5:0] exp_v;
      int         n;
      bit         found;
      en = 4'b0000; @(negedge clk);
      en = 4'b0100; cfg_chan = 2'd2; cfg_div = 16'd7; cfg_valid = 1'b1; #1;
      total_cnt++;
      if (cfg_ready !== 1'b1) $display("FAIL b2b_ready_first: got %b expected 1", cfg_ready);
      else pass_cnt++;
      @(negedge clk); cfg_div = 16'd3; #1;
      total_cnt++;
      if (cfg_ready !== 1'b0) $display("FAIL b2b_ready_held: got %b expected 0", cfg_ready);
      else pass_cnt++;
      @(negedge clk); #1;
      total_cnt++;
      if ({cfg_ready, tick[2]} !== 2'b11) $display("FAIL b2b_apply_first: got %b expected 11", {cfg_ready, tick[2]});
      else pass_cnt++;
      @(negedge clk); cfg_valid = 1'b0; #1;
      total_cnt++;
      if (cfg_ready !== 1'b0) $display("FAIL b2b_ready_second_pend: got %b expected 0", cfg_ready);
      else pass_cnt++;
      n = 0; found = 1'b0;
      for (int k = 1; k <= 20 && !found; k++) begin
         @(negedge clk);
         if (tick[2]) begin found = 1'b1; n = k; end
      end
      total_cnt++;
      if (n !== 6) $display("FAIL b2b_div7_wrap_cycles: got %0d expected 6", n);
      else pass_cnt++;
      exp_v = 6'b001001;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         total_cnt++;
         if ({div_out[2], tick[2]} !== {2{exp_v[5-i]}})
            $display("FAIL b2b_div3 cyc%0d: got %b expected %b", i, {div_out[2], tick[2]}, {2{exp_v[5-i]}});
         else pass_cnt++;
      end
      $display("back_to_back: ch2 7 then 3 checked");
   endtask

   task automatic test_invalid();
      en = 4'b0000; @(negedge clk);
      cfg_chan = 2'd0; cfg_div = 16'd0; cfg_valid = 1'b1; #1;
      total_cnt++;
      if (cfg_ready !== 1'b1) $display("FAIL inv_zero_ready: got %b expected 1", cfg_ready);
      else pass_cnt++;
      @(negedge clk); cfg_valid = 1'b0; #1;
      total_cnt++;
      if ({cfg_err, cfg_ready} !== 2'b11) $display("FAIL inv_zero_err: got %b expected 11", {cfg_err, cfg_ready});
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (cfg_err !== 1'b0) $display("FAIL inv_zero_err_clear: got %b expected 0", cfg_err);
      else pass_cnt++;
      cfg_chan5 = 3'd5; cfg_div5 = 16'd3; cfg_valid5 = 1'b1; #1;
      total_cnt++;
      if (cfg_ready5 !== 1'b1) $display("FAIL inv_range_ready: got %b expected 1", cfg_ready5);
      else pass_cnt++;
      @(negedge clk); cfg_valid5 = 1'b0;
      total_cnt++;
      if ({cfg_err5, cfg_err} !== 2'b10) $display("FAIL inv_range_err: got %b expected 10", {cfg_err5, cfg_err});
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (cfg_err5 !== 1'b0) $display("FAIL inv_range_err_clear: got %b expected 0", cfg_err5);
      else pass_cnt++;
      en = 4'b0001; en5 = 5'b11111;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         total_cnt++;
         if ({div_out, div_out5} !== ((i % 2 == 1) ? 9'b0001_11111 : 9'b0000_00000))
            $display("FAIL inv_div_unchanged cyc%0d: got %b expected %b", i, {div_out, div_out5},
                     (i % 2 == 1) ? 9'b0001_11111 : 9'b0000_00000);
         else pass_cnt++;
      end
      en5 = '0;
      $display("invalid: zero divisor and out-of-range channel checked");
   endtask

   task automatic test_sync();
      logic [11:0] exp_o0, exp_t0, exp_o3, exp_t3;
      en = 4'b0000; cfg_chan = 2'd0; cfg_div = 16'd4; cfg_valid = 1'b1;
      @(negedge clk); cfg_chan = 2'd3; cfg_div = 16'd6;
      @(negedge clk); cfg_valid = 1'b0;
      @(negedge clk); en = 4'b0001;
      repeat (2) @(negedge clk);
      en = 4'b1001;
      repeat (3) @(negedge clk);
      sync = 1'b1;
      @(negedge clk); sync = 1'b0;
      total_cnt++;
      if ({div_out, tick} !== 8'b0) $display("FAIL sync_clear: got %b expected 00000000", {div_out, tick});
      else pass_cnt++;
      exp_o0 = 12'b100110011001; exp_t0 = 12'b000100010001;
      exp_o3 = 12'b110001110001; exp_t3 = 12'b000001000001;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         total_cnt++;
         if ({div_out[0], tick[0], div_out[3], tick[3]} !== {exp_o0[11-i], exp_t0[11-i], exp_o3[11-i], exp_t3[11-i]})
            $display("FAIL sync_phase cyc%0d: got %b expected %b", i + 1, {div_out[0], tick[0], div_out[3], tick[3]},
                     {exp_o0[11-i], exp_t0[11-i], exp_o3[11-i], exp_t3[11-i]});
         else pass_cnt++;
      end
      $display("sync: ch0 div4 and ch3 div6 realigned");
   endtask

   task automatic test_async_reset();
      logic [3:0] exp;
      en = 4'b0000; @(negedge clk);
      en = 4'b0010; cfg_chan = 2'd1; cfg_div = 16'd3; cfg_valid = 1'b1;
      @(negedge clk); cfg_valid = 1'b0; #1;
      total_cnt++;
      if ({cfg_ready, div_out[1]} !== 2'b01) $display("FAIL arst_pre: got %b expected 01", {cfg_ready, div_out[1]});
      else pass_cnt++;
      #2 rst = 1'b0;
      #1;
      total_cnt++;
      if ({div_out, tick, cfg_ready} !== 9'b0000_0000_1)
         $display("FAIL arst_immediate: got %b expected 000000001", {div_out, tick, cfg_ready});
      else pass_cnt++;
      @(negedge clk); @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         exp = (i % 2 == 1) ? 4'b0010 : 4'b0000;
         total_cnt++;
         if ({div_out, tick} !== {exp, exp}) $display("FAIL arst_div_rst cyc%0d: got %b expected %b", i, {div_out, tick}, {exp, exp});
         else pass_cnt++;
      end
      $display("async_reset: pending divisor discarded");
   endtask

   initial begin
      test_reset();
      test_reprogram();
      test_back_to_back();
      test_invalid();
      test_sync();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
